// File: rtl/split_if.sv
// Handshake bundle for split: one data channel and one select channel in,
// two data channels out.
interface split_if #(
    parameter int WIDTH = 8
);
    logic             L_valid;
    logic             L_ready;
    logic [WIDTH-1:0] L_data;
    logic             S_valid;
    logic             S_ready;
    logic             S_sel;
    logic             R0_valid;
    logic             R0_ready;
    logic [WIDTH-1:0] R0_data;
    logic             R1_valid;
    logic             R1_ready;
    logic [WIDTH-1:0] R1_data;

    modport master (
        output L_valid, L_data, S_valid, S_sel, R0_ready, R1_ready,
        input  L_ready, S_ready, R0_valid, R0_data, R1_valid, R1_data
    );

    modport slave (
        input  L_valid, L_data, S_valid, S_sel, R0_ready, R1_ready,
        output L_ready, S_ready, R0_valid, R0_data, R1_valid, R1_data
    );
endinterface

// File: rtl/split.sv
// Routes one data token per select token to R0 or R1, with FL cycles of forward
// latency and BL cycles of recovery. SPLIT_STATS_EN adds per-output handshake counters.
//
// state | meaning
// IDLE  | ready to accept a joint data+select token
// FWD   | forward-latency wait, counter counts FL down to 1
// SEND  | selected output valid, waiting for its ready
// BACK  | recovery after output handshake, counter counts BL down to 1
module split #(
    parameter int WIDTH = 8,
    parameter int FL    = 2,
    parameter int BL    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    split_if.slave      bus
`ifdef SPLIT_STATS_EN
    ,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, FWD, SEND, BACK} state_t;

    localparam logic [7:0] FL_C = 8'(FL);
    localparam logic [7:0] BL_C = 8'(BL);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] data_q;
    logic             sel_q;
    logic             accept;
    logic             out_hs;

    assign accept = (state == IDLE) && bus.L_valid && bus.S_valid;
    // Ready on the unselected output never matters.
    assign out_hs = (state == SEND) && (sel_q ? bus.R1_ready : bus.R0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            data_q <= '0;
            sel_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q <= bus.L_data;
                        sel_q  <= bus.S_sel;
                        cnt    <= FL_C;
                    end
                end
                FWD:     cnt <= cnt - 8'd1;
                SEND:    if (out_hs) cnt <= BL_C;
                BACK:    cnt <= cnt - 8'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (FL == 0) ? SEND : FWD;
            FWD:     if (cnt == 8'd1) state_nxt = SEND;
            SEND:    if (out_hs) state_nxt = (BL == 0) ? IDLE : BACK;
            BACK:    if (cnt == 8'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Input ready is gated by rst_n so it is already low while reset is held.
    always_comb begin
        bus.L_ready  = accept && rst_n;
        bus.S_ready  = accept && rst_n;
        bus.R0_valid = (state == SEND) && !sel_q;
        bus.R1_valid = (state == SEND) && sel_q;
        bus.R0_data  = data_q;
        bus.R1_data  = data_q;
    end

`ifdef SPLIT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (bus.R0_valid && bus.R0_ready) cnt0 <= cnt0 + 16'd1;
            if (bus.R1_valid && bus.R1_ready) cnt1 <= cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_split.sv
// Directed bench for split: scoreboard of {sel,data} pushed at accept and
// popped by a monitor at each output handshake.
module tb_split;
    localparam int WIDTH = 8;
    localparam int FL    = 2;
    localparam int BL    = 1;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    split_if #(.WIDTH(WIDTH)) bus ();

`ifdef SPLIT_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    split #(.WIDTH(WIDTH), .FL(FL), .BL(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SPLIT_STATS_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WIDTH:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        @(negedge clk);
        while (!bus.L_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("one_hot_valid", {31'd0, bus.R0_valid && bus.R1_valid}, 0);
            if ((bus.R0_valid && bus.R0_ready) || (bus.R1_valid && bus.R1_ready)) begin
                logic [WIDTH:0] e;
                chk("out_pending", {31'd0, sb.size() > 0}, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_sel", {31'd0, bus.R1_valid}, {31'd0, e[WIDTH]});
                    chk("out_data", bus.R1_valid ? bus.R1_data : bus.R0_data, e[WIDTH-1:0]);
                end
            end
        end
    end

    initial begin
        int prev;
        rst_n        = 1'b0;
        bus.L_valid  = 1'b1;
        bus.S_valid  = 1'b1;
        bus.L_data   = '0;
        bus.S_sel    = 1'b0;
        bus.R0_ready = 1'b0;
        bus.R1_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_l_ready", bus.L_ready, 0);
        chk("rst_s_ready", bus.S_ready, 0);
        chk("rst_r0_valid", bus.R0_valid, 0);
        chk("rst_r1_valid", bus.R1_valid, 0);

        // first accept on first edge after release, sel 0 / 0xA5
        @(posedge clk); #1;
        rst_n        = 1'b1;
        bus.L_data   = 8'hA5;
        bus.S_sel    = 1'b0;
        bus.R0_ready = 1'b1;
        bus.R1_ready = 1'b1;
        @(negedge clk);
        chk("acc_l_ready", bus.L_ready, 1);
        chk("acc_s_ready", bus.S_ready, 1);
        sb.push_back({1'b0, 8'hA5});
        @(posedge clk); #1;
        bus.L_valid = 1'b0;
        bus.S_valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            chk("fwd_r0_valid", bus.R0_valid, 0);
            chk("fwd_r1_valid", bus.R1_valid, 0);
        end
        @(negedge clk);
        chk("send_r0_valid", bus.R0_valid, 1);
        chk("send_r1_valid", bus.R1_valid, 0);
        chk("send_r0_data", bus.R0_data, 8'hA5);
        @(negedge clk);
        chk("back_r0_valid", bus.R0_valid, 0);

        // sel 1 / 0x3C held by R1_ready=0; new offers must not be taken
        @(posedge clk); #1;
        bus.R0_ready = 1'b1;
        bus.R1_ready = 1'b0;
        bus.L_valid  = 1'b1;
        bus.S_valid  = 1'b1;
        bus.L_data   = 8'h3C;
        bus.S_sel    = 1'b1;
        @(negedge clk);
        chk("acc2_l_ready", bus.L_ready, 1);
        sb.push_back({1'b1, 8'h3C});
        @(posedge clk); #1;
        bus.L_data = 8'h77;
        bus.S_sel  = 1'b0;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            chk("fwd2_l_ready", bus.L_ready, 0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_r1_valid", bus.R1_valid, 1);
            chk("hold_r1_data", bus.R1_data, 8'h3C);
            chk("hold_r0_valid", bus.R0_valid, 0);
            chk("hold_l_ready", bus.L_ready, 0);
            chk("hold_s_ready", bus.S_ready, 0);
        end
        @(posedge clk); #1;
        bus.L_valid  = 1'b0;
        bus.S_valid  = 1'b0;
        bus.R1_ready = 1'b1;
        @(negedge clk);
        chk("rel_r1_valid", bus.R1_valid, 1);
        wait_drain(20);

        // lone L_valid / lone S_valid are never consumed
        @(posedge clk); #1;
        bus.L_valid = 1'b1;
        bus.S_valid = 1'b0;
        bus.L_data  = 8'h5A;
        bus.S_sel   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lonel_l_ready", bus.L_ready, 0);
            chk("lonel_s_ready", bus.S_ready, 0);
        end
        @(posedge clk); #1;
        bus.L_valid = 1'b0;
        bus.S_valid = 1'b1;
        @(negedge clk);
        chk("lones_s_ready", bus.S_ready, 0);
        @(posedge clk); #1;
        bus.L_valid = 1'b1;
        @(negedge clk);
        chk("join_l_ready", bus.L_ready, 1);
        sb.push_back({1'b1, 8'h5A});
        @(posedge clk); #1;
        bus.L_valid = 1'b0;
        bus.S_valid = 1'b0;
        wait_drain(20);

        // four back-to-back tokens at the minimum period
        @(posedge clk); #1;
        bus.L_valid = 1'b1;
        bus.S_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            bus.L_data = 8'(i + 1);
            bus.S_sel  = i[0];
            wait_ready(30);
            chk("tok_accept", bus.L_ready, 1);
            if (i > 0) chk("tok_period", cyc - prev, FL + BL + 2);
            prev = cyc;
            sb.push_back({i[0], 8'(i + 1)});
            @(posedge clk); #1;
        end
        bus.L_valid = 1'b0;
        bus.S_valid = 1'b0;
        wait_drain(30);

        // reset during FWD discards the token
        repeat (3) @(posedge clk); #1;
        bus.L_valid = 1'b1;
        bus.S_valid = 1'b1;
        bus.L_data  = 8'hEE;
        bus.S_sel   = 1'b0;
        wait_ready(10);
        chk("rstf_accept", bus.L_ready, 1);
        @(posedge clk); #1;
        bus.L_valid = 1'b0;
        bus.S_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstf_r0_valid", bus.R0_valid, 0);
        chk("rstf_r1_valid", bus.R1_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < FL + BL + 6; k++) begin
            @(negedge clk);
            chk("rstf_no_deliver", {31'd0, bus.R0_valid || bus.R1_valid}, 0);
        end

        // reset during SEND drops the valid asynchronously
        @(posedge clk); #1;
        bus.R1_ready = 1'b0;
        bus.L_valid  = 1'b1;
        bus.S_valid  = 1'b1;
        bus.L_data   = 8'hD1;
        bus.S_sel    = 1'b1;
        wait_ready(10);
        @(posedge clk); #1;
        bus.L_valid = 1'b0;
        bus.S_valid = 1'b0;
        repeat (FL) @(posedge clk);
        #3;
        chk("rsts_r1_valid_pre", bus.R1_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rsts_r1_valid", bus.R1_valid, 0);
        @(posedge clk); #1;
        rst_n        = 1'b1;
        bus.R1_ready = 1'b1;
        for (int k = 0; k < FL + BL + 6; k++) begin
            @(negedge clk);
            chk("rsts_no_deliver", {31'd0, bus.R0_valid || bus.R1_valid}, 0);
        end

`ifdef SPLIT_STATS_EN
        @(posedge clk); #1;
        bus.L_valid = 1'b1;
        bus.S_valid = 1'b1;
        bus.S_sel   = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            bus.L_data = 8'(i);
            wait_ready(10);
            sb.push_back({1'b0, 8'(i)});
            @(posedge clk); #1;
        end
        bus.L_valid = 1'b0;
        bus.S_valid = 1'b0;
        wait_drain(20);
        @(negedge clk);
        chk("cnt0_wrap", cnt0, 16'h0001);
        chk("cnt1_zero", cnt1, 16'h0000);
`endif

        chk("sb_final", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/split.md
SPLIT -- requirements
Module: split

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter FL, default 2, range 0..255, giving the forward-latency wait in cycles between accept and offer.
REQ-003 The block SHALL have parameter BL, default 1, range 0..255, giving the backward-latency recovery in cycles after an output handshake.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 L_valid, L_ready, L_data  in, out, in  1, 1, WIDTH  data input channel.
REQ-007 S_valid, S_ready, S_sel  in, out, in  1, 1, 1  select input channel; 0 selects R0 and 1 selects R1.
REQ-008 R0_valid, R0_ready, R0_data  out, in, out  1, 1, WIDTH  output channel 0.
REQ-009 R1_valid, R1_ready, R1_data  out, in, out  1, 1, WIDTH  output channel 1.

Function
REQ-010 A transfer on any channel SHALL occur on a rising edge where valid and ready are both 1.
REQ-011 The FSM SHALL have exactly four states: IDLE, FWD, SEND, BACK.
REQ-012 In IDLE, L_ready and S_ready SHALL both equal (L_valid AND S_valid), so the block accepts the data and select tokens jointly or not at all.
REQ-013 In every state other than IDLE, L_ready and S_ready SHALL both be 0.
REQ-014 On a joint accept, the block SHALL register L_data into data_q and S_sel into sel_q, then go to FWD with an 8-bit counter loaded with FL, or go directly to SEND if FL is 0.
REQ-015 In FWD, the counter SHALL decrement once per cycle and the FSM SHALL move to SEND on the edge where the counter equals 1, so FWD lasts exactly FL cycles.
REQ-016 In SEND, only the selected output (R0 if sel_q is 0, R1 if sel_q is 1) SHALL assert valid, and the other output's valid SHALL stay 0.
REQ-017 R0_data and R1_data SHALL both equal data_q at all times and SHALL be stable while any valid is high.
REQ-018 SEND SHALL hold, with valid and data stable, for as long as the selected ready is 0; ready on the unselected output SHALL be ignored.
REQ-019 On the selected output handshake, the FSM SHALL go to BACK with the counter loaded with BL, or directly to IDLE if BL is 0.
REQ-020 BACK SHALL last exactly BL cycles and then return to IDLE.
REQ-021 If a joint accept occurs in cycle T, the selected output valid SHALL first be high in cycle T+1+FL.
REQ-022 With ready held at 1, the minimum token period SHALL be FL+BL+2 cycles.
REQ-023 S_valid without L_valid, or L_valid without S_valid, SHALL never cause either input to be consumed.

Reset
REQ-024 When rst_n is low, the FSM SHALL go to IDLE, and the counter, data_q and sel_q SHALL be 0, all asynchronously.
REQ-025 While rst_n is low, R0_valid, R1_valid, L_ready and S_ready SHALL all be 0.
REQ-026 Reset asserted in FWD, SEND or BACK SHALL discard the held token, which SHALL never be delivered.
REQ-027 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 When SPLIT_STATS_EN is defined, the block SHALL add outputs cnt0 and cnt1, each 16 bits.
REQ-029 With SPLIT_STATS_EN, cnt0 SHALL increment on each completed R0 handshake and cnt1 on each completed R1 handshake; both SHALL wrap from 0xFFFF to 0x0000 and reset to 0.
REQ-030 When SPLIT_STATS_EN is undefined, the cnt0/cnt1 ports and their logic SHALL be absent, with behaviour otherwise identical.

Verification (WIDTH=8, FL=2, BL=1)
REQ-031 Accept S_sel=0 with L_data=0xA5 in cycle 3 -> R0_valid high in cycle 6 with R0_data=0xA5, and R1_valid stays 0 throughout.
REQ-032 Accept S_sel=1 with L_data=0x3C, then hold R1_ready=0 for 5 cycles -> R1_valid and 0x3C are held, and L_ready and S_ready stay 0 until the handshake completes.
REQ-033 L_valid=1 with S_valid=0 for 4 cycles -> no accept and L_ready stays 0; raising S_valid -> accept on that edge.
REQ-034 Four tokens with sel 0,1,0,1 and data 0x01..0x04, all ready at 1 -> each delivered on the correct output at a 5-cycle period.
REQ-035 Pull rst_n low during FWD -> all valids drop to 0 immediately; after release the FSM is in IDLE and the token is never delivered.
REQ-036 With SPLIT_STATS_EN defined, send 65537 tokens to R0 -> cnt0=0x0001 and cnt1=0x0000.
